// File: rtl/floor_request_filter_pkg.sv
// Shared widths, clear-key default and debounce state encoding for the floor request filter.
package floor_request_filter_pkg;
  localparam int FLOOR_W = 4;
  localparam logic [FLOOR_W-1:0] CLR_CODE_DEF = 4'hF;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } deb_state_e;
endpackage

// File: rtl/request_fifo.sv
// Floor request FIFO with flush and occupied-entry match; registered head, count-based full/empty.
// Push is taken when not full or when a pop frees a slot in the same cycle; flush overrides push and pop.
module request_fifo
  import floor_request_filter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [FLOOR_W-1:0]         push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [FLOOR_W-1:0]         match_code_i,
  output logic                       match_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [FLOOR_W-1:0]         head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [FLOOR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLOOR_W-1:0] head_q, head_d;
  logic               pop_vld, push_vld;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign pop_vld  = pop_i && !empty_o && !flush_i;
  assign push_vld = push_i && !flush_i && (!full_o || pop_vld);
  assign count_o  = cnt_q;
  assign head_o   = head_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (pop_vld)  rd_d = rd_q + PTR_W'(1);
      if (push_vld) wr_d = wr_q + PTR_W'(1);
      if (push_vld && !pop_vld)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push_vld && pop_vld) cnt_d = cnt_q - CNT_W'(1);
    end
    // The new head may be the entry being written this cycle.
    if (cnt_d == '0)                     head_d = '0;
    else if (push_vld && (wr_q == rd_d)) head_d = push_dat_i;
    else                                 head_d = mem_q[rd_d];
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    off     = '0;
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_q;
      if ((mem_q[i] == match_code_i) && ({1'b0, off} < cnt_q)) match_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      if (push_vld) mem_q[wr_q] <= push_dat_i;
    end
  end
endmodule

// File: rtl/floor_request_filter.sv
// Debounces scanned key codes into floor requests, filters range/duplicates, queues them; 2 clk tick-to-valid.
// Queue drains via req_valid/req_ready; a press arriving at a full FIFO with no pop is dropped with drop_pulse.
module floor_request_filter
  import floor_request_filter_pkg::*;
#(
  parameter int                 FLOORS    = 4,
  parameter int                 DEB_TICKS = 3,
  parameter int                 DEPTH     = 4,
  parameter logic [FLOOR_W-1:0] CLR_CODE  = CLR_CODE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scan_tick,
  input  logic                       key_hit,
  input  logic [FLOOR_W-1:0]         key_code,
  input  logic                       req_ready,
  output logic                       req_valid,
  output logic [FLOOR_W-1:0]         req_floor,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       drop_pulse,
  output logic [FLOOR_W-1:0]         stable_code
);
  localparam int             DC_W     = $clog2(DEB_TICKS+1);
  localparam logic [DC_W-1:0] DEB_LAST = DC_W'(DEB_TICKS-1);

  deb_state_e         state_q, state_d;
  logic [DC_W-1:0]    cnt_q, cnt_d;
  logic [FLOOR_W-1:0] cand_q, cand_d;
  logic [FLOOR_W-1:0] stable_q, stable_d;
  logic               ev_q, ev_d;
  logic               drop_q, drop_d;
  logic               fifo_full, fifo_empty, fifo_match;
  logic               flush_vld, push_vld, pop_vld, in_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    ev_d     = 1'b0;
    if (scan_tick) begin
      case (state_q)
        RELEASED: if (key_hit) begin
          cand_d = key_code;
          if (DEB_TICKS == 1) begin
            state_d  = PRESSED;
            ev_d     = 1'b1;
            stable_d = key_code;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = DC_W'(1);
          end
        end
        PRESS_CHK: if (key_hit && (key_code == cand_q)) begin
          if (cnt_q >= DEB_LAST) begin
            state_d  = PRESSED;
            cnt_d    = '0;
            ev_d     = 1'b1;
            stable_d = cand_q;
          end else begin
            cnt_d = cnt_q + DC_W'(1);
          end
        end else begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
        // A different code while held is ignored: only a release leaves PRESSED.
        PRESSED: if (!key_hit) begin
          if (DEB_TICKS == 1) begin
            state_d = RELEASED;
          end else begin
            state_d = RELEASE_CHK;
            cnt_d   = DC_W'(1);
          end
        end
        RELEASE_CHK: if (!key_hit) begin
          if (cnt_q >= DEB_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DC_W'(1);
          end
        end else begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // stable_q already holds the event code during the event cycle.
  assign in_range  = (stable_q < FLOOR_W'(FLOORS));
  assign flush_vld = ev_q && (stable_q == CLR_CODE);
  assign push_vld  = ev_q && !flush_vld && in_range && !fifo_match;
  assign pop_vld   = req_valid && req_ready;
  assign drop_d    = push_vld && fifo_full && !pop_vld;

  request_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_vld),
    .push_dat_i   (stable_q),
    .pop_i        (pop_vld),
    .flush_i      (flush_vld),
    .match_code_i (stable_q),
    .match_o      (fifo_match),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (req_floor)
  );

  assign req_valid   = !fifo_empty;
  assign drop_pulse  = drop_q;
  assign stable_code = stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RELEASED;
      cnt_q    <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      ev_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      ev_q     <= ev_d;
      drop_q   <= drop_d;
    end
  end
endmodule

// File: tb/tb_floor_request_filter.sv
// Directed bench for floor_request_filter with FLOORS=8, DEB_TICKS=3, DEPTH=4.
module tb_floor_request_filter;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_tick;
  logic          key_hit;
  logic [3:0]    key_code;
  logic          req_ready;
  logic          req_valid;
  logic [3:0]    req_floor;
  logic [CW-1:0] fifo_count;
  logic          drop_pulse;
  logic [3:0]    stable_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  floor_request_filter #(
    .FLOORS(8), .DEB_TICKS(3), .DEPTH(DEPTH), .CLR_CODE(4'hF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_tick   (scan_tick),
    .key_hit     (key_hit),
    .key_code    (key_code),
    .req_ready   (req_ready),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .fifo_count  (fifo_count),
    .drop_pulse  (drop_pulse),
    .stable_code (stable_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic h, input logic [3:0] c);
    key_hit   = h;
    key_code  = c;
    scan_tick = 1'b1;
    @(posedge clk);
    #1;
    scan_tick = 1'b0;
  endtask

  // Three qualifying ticks; returns during the event cycle.
  task automatic press_hold(input logic [3:0] c);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) idle(1);
      tick(1'b1, c);
    end
  endtask

  task automatic release_key();
    repeat (3) begin
      idle(1);
      tick(1'b0, 4'h0);
    end
    idle(1);
  endtask

  task automatic press(input logic [3:0] c);
    press_hold(c);
    idle(1);
    release_key();
  endtask

  task automatic pop_one();
    req_ready = 1'b1;
    idle(1);
    req_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] drain_exp [4];
    drain_exp[0] = 4'd1; drain_exp[1] = 4'd2; drain_exp[2] = 4'd3; drain_exp[3] = 4'd5;

    rst = 1'b1; scan_tick = 1'b0; key_hit = 1'b0; key_code = 4'h0; req_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    chk("rst_valid", req_valid, 0);
    chk("rst_floor", req_floor, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_stable", stable_code, 0);

    // Clean press of floor 2, held 5 ticks
    press_hold(4'd2);
    chk("lat_evt_valid", req_valid, 0);
    idle(1);
    chk("clean_valid", req_valid, 1);
    chk("clean_floor", req_floor, 2);
    chk("clean_count", fifo_count, 1);
    chk("clean_stable", stable_code, 2);
    idle(1); tick(1'b1, 4'd2); idle(1); tick(1'b1, 4'd2); idle(2);
    chk("no_repeat_count", fifo_count, 1);
    release_key();
    pop_one();
    chk("pop_count", fifo_count, 0);
    chk("pop_valid", req_valid, 0);
    chk("pop_floor", req_floor, 0);
    req_ready = 1'b1; idle(2); req_ready = 1'b0;
    chk("pop_empty_count", fifo_count, 0);

    // Bounce: 2 ticks, release, then 3 ticks
    tick(1'b1, 4'd1); idle(1); tick(1'b1, 4'd1); idle(1); tick(1'b0, 4'd0); idle(1);
    tick(1'b1, 4'd1); idle(1); tick(1'b1, 4'd1); idle(2);
    chk("bounce_early", fifo_count, 0);
    tick(1'b1, 4'd1); idle(1);
    chk("bounce_count", fifo_count, 1);
    chk("bounce_floor", req_floor, 1);
    release_key();
    pop_one();

    // Fill, duplicate, drop, out of range
    press(4'd0); press(4'd1); press(4'd2); press(4'd3);
    chk("full_count", fifo_count, 4);
    chk("full_head", req_floor, 0);
    press_hold(4'd0); idle(1);
    chk("dup_drop", drop_pulse, 0);
    chk("dup_count", fifo_count, 4);
    release_key();
    press_hold(4'd5); idle(1);
    chk("drop_pulse", drop_pulse, 1);
    chk("drop_count", fifo_count, 4);
    idle(1);
    chk("drop_one_cycle", drop_pulse, 0);
    release_key();
    press_hold(4'd8); idle(1);
    chk("range_drop", drop_pulse, 0);
    chk("range_count", fifo_count, 4);
    release_key();

    // Full with pop in the event cycle
    press_hold(4'd5);
    req_ready = 1'b1;
    idle(1);
    req_ready = 1'b0;
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_drop", drop_pulse, 0);
    release_key();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), req_floor, drain_exp[i]);
      pop_one();
    end
    chk("drain_count", fifo_count, 0);

    // Clear key flush
    press(4'd1); press(4'd3);
    chk("pre_clr_count", fifo_count, 2);
    press_hold(4'hF); idle(1);
    chk("clr_count", fifo_count, 0);
    chk("clr_valid", req_valid, 0);
    chk("clr_floor", req_floor, 0);
    chk("clr_stable", stable_code, 15);
    release_key();

    // Reset during PRESS_CHK with two entries queued
    press(4'd1); press(4'd3);
    chk("pre_rst_count", fifo_count, 2);
    tick(1'b1, 4'd6); idle(1); tick(1'b1, 4'd6); idle(1);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("mid_rst_valid", req_valid, 0);
    chk("mid_rst_floor", req_floor, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_drop", drop_pulse, 0);
    chk("mid_rst_stable", stable_code, 0);
    tick(1'b1, 4'd6); idle(1); tick(1'b1, 4'd6); idle(2);
    chk("post_rst_early", fifo_count, 0);
    tick(1'b1, 4'd6); idle(1);
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_floor", req_floor, 6);
    chk("post_rst_stable", stable_code, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/floor_request_filter.md
Name: floor_request_filter

Overview:
- Sits between the keypad scanner and the request queue.
- Debounces the scanner's raw key code, which is sampled on the ~100 Hz scan strobe, and turns each clean press into one floor request.
- Drops out-of-range codes and floors already pending, and buffers accepted requests in a small FIFO.
- The queue drains the FIFO over a valid/ready handshake; a dedicated clear key flushes all pending requests.

Parameters:
- FLOORS, 4: valid floor codes are 0..FLOORS-1 (FLOORS <= 15).
- DEB_TICKS, 3: consecutive identical scan samples required to change debounced state (>= 1).
- DEPTH, 4: FIFO entries (power of two, >= 2).
- CLR_CODE, 4'hF: key code that flushes the FIFO.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- scan_tick  in  1  one-cycle strobe; sampling instant for key inputs
- key_hit  in  1  scanner reports a key down
- key_code  in  4  scanner key code; meaningful only when key_hit=1
- req_ready  in  1  queue accepts the head entry this cycle
- req_valid  out  1  FIFO non-empty
- req_floor  out  4  head floor; 0 when empty
- fifo_count  out  $clog2(DEPTH+1)  occupied entries
- drop_pulse  out  1  one cycle: valid floor press lost because FIFO full
- stable_code  out  4  last debounced pressed code (for display)

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - all outputs 0; FIFO empty; debounce FSM in RELEASED; counter 0.
  - rst mid-debounce or with the FIFO occupied discards everything; no event is emitted.
- Sampling: inputs are examined only in cycles with scan_tick=1; the FSM and counter hold otherwise.
- Sample S = {key_hit, key_code}.
- Debounce FSM:
  - RELEASED: S pressed -> PRESS_CHK; latch cand=key_code; cnt=1.
  - PRESS_CHK:
    - S pressed with same code -> cnt++.
    - When cnt reaches DEB_TICKS -> PRESSED; emit press event (code=cand); stable_code<=cand.
    - Released or different code -> RELEASED; cnt=0.
  - PRESSED:
    - released -> RELEASE_CHK; cnt=1.
    - A different code while held is ignored; there is no auto-repeat.
  - RELEASE_CHK:
    - released -> cnt++; at DEB_TICKS -> RELEASED.
    - pressed again -> PRESSED; no new event.
  - DEB_TICKS=1: the transition happens on the first qualifying tick.
- Press event: internal one-cycle pulse in the cycle after the qualifying scan_tick edge. Classification:
  - code == CLR_CODE: flush. FIFO is emptied at the end of that cycle; any pop in the same cycle is discarded.
  - code >= FLOORS (and not CLR_CODE): ignored silently.
  - code matches any occupied entry, including the head being popped this cycle: duplicate, ignored silently.
  - otherwise push; accepted if not full, or if full and req_ready&&req_valid in the same cycle.
  - full with no pop: entry lost; drop_pulse=1 next cycle.
- Latency: qualifying scan_tick edge -> event cycle -> write at its end -> req_valid high one cycle later (2 clk after the tick edge) when the FIFO was empty.
- FIFO:
  - read/write pointers wrap modulo DEPTH; count-based full/empty.
  - pop when req_valid&&req_ready; req_ready with an empty FIFO has no effect.
  - req_floor is a registered view of the head.
  - Simultaneous push+pop keeps fifo_count unchanged.
- Widths: fifo_count is exactly $clog2(DEPTH+1) bits; codes compare as unsigned 4-bit.

Decomposition:
- Shared package: FLOOR_W=4, CLR_CODE default, debounce state enum {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK}.
- One sub-module: request_fifo.
  - Holds DEPTH entries with push/pop, flush, membership-match output, count/full/empty.
  - The debounce FSM and classification stay in the top.

Test Plan:
- Clean press: key_hit=1, code=2 held for 5 ticks, DEB_TICKS=3 -> req_valid rises 2 clk after the 3rd tick; req_floor=2; count=1; exactly one entry.
- Bounce: code 1 for 2 ticks, released 1 tick, then 1 for 3 ticks -> single entry 1 after the last qualifying tick; no entry earlier.
- Full and drop:
  - Press floors 0,1,2,3 with req_ready=0 -> count=4.
  - Press 0 -> duplicate, no drop_pulse.
  - Press 3 again after popping 3? Use FLOORS=8 instead: press 5 -> drop_pulse for one cycle; count stays 4.
- Full + pop same cycle: full FIFO, req_ready=1 in the cycle of a press of new floor 5 -> head popped, 5 written; count stays 4; no drop.
- Clear: FIFO holds {1,3}; press CLR_CODE -> count=0, req_valid=0 one cycle after the event; stable_code=4'hF.
- Reset mid-operation: rst asserted during PRESS_CHK with 2 entries queued -> next cycle all outputs 0; the following ticks of the same held key require a full DEB_TICKS again before an event.
